// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time over a
// req/rvalid handshake and holds it until retired. Optional: FETCH_MISALIGN_TRAP_EN.
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        instr_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] instr_q, instr_next;
  logic [31:0] redirect_pc;
  logic        misaligned;

  assign PCPlus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned taken target is kept verbatim so the faulting address is visible on PC.
  assign redirect_pc = PCTarget;
  assign misaligned  = PCSrc && (PCTarget[1:0] != 2'b00);
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^PCTarget[1:0];
  assign redirect_pc        = {PCTarget[31:2], 2'b00};
  assign misaligned         = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next = state;
    pc_next    = pc_q;
    instr_next = instr_q;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_next = imem_rdata;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_next    = PCSrc ? redirect_pc : PCPlus4;
          instr_next = NOP_INSTR;
          state_next = misaligned ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      instr_q <= instr_next;
    end
  end

  // Handshake and status outputs decode the registered state only.
  assign imem_req    = (state == S_REQ);
  assign instr_valid = (state == S_HOLD);
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (state == S_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, sequential fetch, redirect,
// stalls with spurious responses, PC wrap, async reset mid-WAIT, misaligned redirect.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .PCSrc       (pc_src),
    .PCTarget    (pc_target),
    .instr_ready (instr_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .Instr       (instr),
    .instr_valid (instr_valid),
    .PC          (pc),
    .PCPlus4     (pc_plus4),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic retire(input logic src, input logic [31:0] tgt);
    pc_src      = src;
    pc_target   = tgt;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
  endtask

  // Called in the REQ cycle; answers lat cycles after it and returns in HOLD.
  task automatic respond(input int lat, input logic [31:0] data);
    @(negedge clk);
    repeat (lat - 1) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", instr_valid); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0h want 0", fetch_fault); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pcplus4: got %h want 00000004", pc_plus4); end
  endtask

  task automatic test_first_fetch();
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL first_req_width: got %0h want 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL first_wait_valid: got %0h want 0", instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %0h want 1", instr_valid); end
    total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL first_instr: got %h want 00500093", instr); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL first_pc: got %h want 00000000", pc); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL first_pcplus4: got %h want 00000004", pc_plus4); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    logic [31:0] addrs [3];
    words = '{32'h0000_0113, 32'h0020_0193, 32'h0030_0213};
    addrs = '{32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    for (int i = 0; i < 3; i++) begin
      retire(1'b0, 32'h0);
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_req[%0d]: got %0h want 1", i, imem_req); end
      total++; if (imem_addr !== addrs[i]) begin bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, addrs[i]); end
      total++; if (instr !== NOP) begin bad++; $display("FAIL seq_nop[%0d]: got %h want %h", i, instr, NOP); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_novalid[%0d]: got %0h want 0", i, instr_valid); end
      @(negedge clk);
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_req_width[%0d]: got %0h want 0", i, imem_req); end
      imem_rvalid = 1'b1; imem_rdata = words[i];
      @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d]: got %0h want 1", i, instr_valid); end
      total++; if (instr !== words[i]) begin bad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, words[i]); end
    end
  endtask

  task automatic test_redirect();
    retire(1'b0, 32'h0);
    respond(1, 32'h0000_0463);
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL redir_pc_before: got %h want 00000010", pc); end
    retire(1'b1, 32'h40);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL redir_req: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr: got %h want 00000040", imem_addr); end
    respond(1, 32'h0010_0093);
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL redir_pc: got %h want 00000040", pc); end
    total++; if (pc_plus4 !== 32'h44) begin bad++; $display("FAIL redir_pcplus4: got %h want 00000044", pc_plus4); end
  endtask

  task automatic test_stall();
    retire(1'b0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stall_valid[%0d]: got %0h want 0", k, instr_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d]: got %0h want 0", k, imem_req); end
      @(negedge clk);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0513;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_after: got %0h want 1", instr_valid); end
    total++; if (instr !== 32'h00A0_0513) begin bad++; $display("FAIL stall_instr: got %h want 00a00513", instr); end
    total++; if (pc !== 32'h44) begin bad++; $display("FAIL stall_pc: got %h want 00000044", pc); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    total++; if (instr !== 32'h00A0_0513) begin bad++; $display("FAIL spurious_instr: got %h want 00a00513", instr); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL spurious_valid: got %0h want 1", instr_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL spurious_req: got %0h want 0", imem_req); end
  endtask

  task automatic test_wrap();
    retire(1'b1, 32'hFFFF_FFFC);
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    respond(2, 32'h0000_006F);
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pcplus4: got %h want 00000000", pc_plus4); end
    retire(1'b0, 32'h0);
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
    respond(1, 32'h0000_0093);
  endtask

  task automatic test_reset_mid_wait();
    retire(1'b0, 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_async_pc: got %h want 00000000", pc); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL rst_async_instr: got %h want %h", instr, NOP); end
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      bad++; $display("FAIL rst_async_flags: got req=%0h valid=%0h fault=%0h want 0 0 0", imem_req, instr_valid, fetch_fault);
    end
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_held_req: got %0h want 0", imem_req); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_refetch_req: got %0h want 1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_refetch_addr: got %h want 00000000", imem_addr); end
    respond(1, 32'h0050_0093);
    total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL rst_refetch_instr: got %h want 00500093", instr); end
  endtask

  task automatic test_misalign();
    retire(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %0h want 1", fetch_fault); end
    total++; if (pc !== 32'h42) begin bad++; $display("FAIL mis_pc: got %h want 00000042", pc); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_valid: got %0h want 0", instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      total++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1) begin
        bad++; $display("FAIL mis_sticky[%0d]: got req=%0h fault=%0h want 0 1", k, imem_req, fetch_fault);
      end
      @(negedge clk);
    end
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    total++; if (instr !== NOP) begin bad++; $display("FAIL mis_instr: got %h want %h", instr, NOP); end
`else
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL mis_align_addr: got %h want 00000040", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mis_align_req: got %0h want 1", imem_req); end
    respond(1, 32'h0000_0013);
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL mis_nofault: got %0h want 0", fetch_fault); end
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL mis_align_pc: got %h want 00000040", pc); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_redirect();
    test_stall();
    test_wrap();
    test_reset_mid_wait();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
